// File: rtl/mcdf_chnl_arbiter.sv
// MCDF channel arbiter: picks one eligible slave channel by priority/round-robin,
// requests a formatter slot and streams one packet. Optional watchdog: MCDF_ARB_WDOG_EN.
module mcdf_chnl_arbiter #(
  parameter int NCH  = 3,
  parameter int DW   = 32,
  parameter int TOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   ch_en,
  input  logic [2*NCH-1:0] ch_prio,
  input  logic [3*NCH-1:0] ch_len,
  input  logic [NCH-1:0]   ch_req,
  input  logic [DW*NCH-1:0] ch_data,
  output logic [NCH-1:0]   ch_ack,
  output logic             fmt_req,
  input  logic             fmt_grant,
  output logic [1:0]       fmt_chid,
  output logic [5:0]       fmt_length,
  output logic             fmt_valid,
  input  logic             fmt_ready,
  output logic [DW-1:0]    fmt_data,
  output logic             fmt_start,
  output logic             fmt_end,
  output logic             arb_busy,
  output logic             arb_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SEND} state_t;

  state_t      r_state;
  logic        r_req;
  logic        r_valid;
  logic [1:0]  r_chid;
  logic [1:0]  r_ptr;
  logic [5:0]  r_len;
  logic [5:0]  r_cnt;

  logic [NCH-1:0] w_elig;
  logic           w_any;
  logic [1:0]     w_minp;
  logic [1:0]     w_win;
  logic [5:0]     w_win_len;
  int             w_best_d;
  int             w_d;
  logic [DW-1:0]  w_data;
  logic           w_last;

  function automatic logic [5:0] len_dec(input logic [2:0] code);
    return code[2] ? 6'd32 : (6'd1 << code[1:0]);
  endfunction

  assign w_elig = ch_en & ch_req;
  assign w_any  = |w_elig;

  // Winner: lowest priority value, ties resolved by distance from r_ptr+1.
  always_comb begin
    w_minp = 2'd3;
    for (int i = 0; i < NCH; i++) begin
      if (w_elig[i] && (ch_prio[2*i +: 2] < w_minp)) w_minp = ch_prio[2*i +: 2];
    end
    w_best_d  = NCH;
    w_d       = 0;
    w_win     = '0;
    w_win_len = 6'd1;
    for (int i = 0; i < NCH; i++) begin
      w_d = i - int'(r_ptr) - 1;
      if (w_d < 0) w_d = w_d + NCH;
      if (w_elig[i] && (ch_prio[2*i +: 2] == w_minp) && (w_d < w_best_d)) begin
        w_best_d  = w_d;
        w_win     = 2'(i);
        w_win_len = len_dec(ch_len[3*i +: 3]);
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_valid && (r_chid == 2'(i))) w_data = ch_data[DW*i +: DW];
    end
  end

  assign w_last = (r_cnt == r_len - 6'd1);

`ifdef MCDF_ARB_WDOG_EN
  localparam int WW = (TOUT > 1) ? $clog2(TOUT + 1) : 1;
  logic [WW-1:0] r_wdog;
  logic          r_err;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_chid  <= '0;
      r_ptr   <= 2'(NCH - 1);
      r_len   <= '0;
      r_cnt   <= '0;
`ifdef MCDF_ARB_WDOG_EN
      r_wdog  <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_chid  <= w_win;
            r_len   <= w_win_len;
            r_req   <= 1'b1;
            r_state <= S_REQ;
`ifdef MCDF_ARB_WDOG_EN
            r_wdog  <= '0;
`endif
          end
        end
        S_REQ: begin
          if (fmt_grant) begin
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_SEND;
`ifdef MCDF_ARB_WDOG_EN
          end else if (r_wdog == WW'(TOUT - 1)) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_ptr   <= r_chid;
            r_state <= S_IDLE;
          end else begin
            r_wdog  <= r_wdog + 1'b1;
`endif
          end
        end
        S_SEND: begin
          if (fmt_ready) begin
            if (w_last) begin
              r_valid <= 1'b0;
              r_cnt   <= '0;
              r_ptr   <= r_chid;
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= r_cnt + 6'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ack
      assign ch_ack[gi] = r_valid & fmt_ready & (r_chid == 2'(gi));
    end
  endgenerate

  assign fmt_req    = r_req;
  assign fmt_chid   = r_chid;
  assign fmt_length = r_len;
  assign fmt_valid  = r_valid;
  assign fmt_data   = w_data;
  assign fmt_start  = r_valid & (r_cnt == 6'd0);
  assign fmt_end    = r_valid & w_last;
  assign arb_busy   = (r_state != S_IDLE);

`ifdef MCDF_ARB_WDOG_EN
  assign arb_err = r_err;
`else
  assign arb_err = 1'b0;
`endif

endmodule
